// File: rtl/shift_add_mult.sv
// Sequential 32x32 shift-and-add multiplier driving an external combinational shifter.
// Optional early exit on exhausted multiplier bits: define SHIFT_MULT_EARLY_EXIT_EN.
module shift_add_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        overflow,
  output logic [31:0] sh_in,
  output logic [4:0]  sh_amt,
  output logic        sh_sel,
  input  logic [31:0] sh_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] acc;
  logic [4:0]  i;
  logic        ovf;

  logic [32:0] sum;
  logic [31:0] acc_next;
  logic        ovf_next;
  logic        last;

  // The shifter sees the latched multiplicand and the current bit index.
  assign sh_in  = a_reg;
  assign sh_amt = i;
  assign sh_sel = 1'b0;

  // NOTE: every always_comb output gets a value before any condition, so no latch is inferred.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, (b_reg[i] ? sh_out : 32'd0)};
    acc_next = sum[31:0];
    // Bits of a_reg in the top i positions fall off the shifter for a taken bit.
    ovf_next = ovf | sum[32] | (b_reg[i] & (|(a_reg & ~(32'hFFFF_FFFF >> i))));
    last     = (i == 5'd31);
`ifdef SHIFT_MULT_EARLY_EXIT_EN
    last     = last | ((b_reg >> ({1'b0, i} + 6'd1)) == 32'd0);
`endif
  end

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      i        <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            i     <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_next;
          ovf <= ovf_next;
          if (last) begin
            product  <= acc_next;
            overflow <= ovf_next;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            i <= i + 5'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
